// File: rtl/pass_checker.sv
// pass_checker: 8-digit hex keypad password checker with a timed door-open window.
// Define PASS_CHECKER_LOCKOUT_EN to add the consecutive-failure lockout.
module pass_checker #(
    parameter int OPEN_CYCLES    = 16,
    parameter int MAX_TRIES      = 3,
    parameter int LOCKOUT_CYCLES = 64
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] keyPass,
    input  logic        digitValid,
    input  logic [3:0]  digitIn,
    input  logic        enterKey,
    input  logic        clearKey,
    output logic        doorOpen,
    output logic        failPulse,
    output logic        locked,
    output logic [3:0]  digitCount,
    output logic        busy
);
    // One counter width covers the door timer, the lockout timer and the attempt count.
    localparam int TMAX = (OPEN_CYCLES > LOCKOUT_CYCLES) ? OPEN_CYCLES : LOCKOUT_CYCLES;
    localparam int CMAX = (TMAX > MAX_TRIES) ? TMAX : MAX_TRIES;
    localparam int CW   = $clog2(CMAX + 1);
    localparam logic [3:0] FULL = 4'd8;

    typedef enum logic [2:0] {
        IDLE,
        ENTRY,
        CHECK,
        OPEN,
        FAIL
`ifdef PASS_CHECKER_LOCKOUT_EN
        , LOCKOUT
`endif
    } state_t;

    state_t        state, nextState;
    logic [31:0]   entryReg, entryNext;
    logic [3:0]    countNext;
    logic [CW-1:0] timer, timerNext;
    logic          mismatch;
`ifdef PASS_CHECKER_LOCKOUT_EN
    logic [CW-1:0] failCount, failNext;
`endif

    always_comb begin
        // NOTE: every value written here gets a default first, so no latch is inferred.
        nextState = state;
        entryNext = entryReg;
        countNext = digitCount;
        timerNext = timer;
        mismatch  = 1'b0;
`ifdef PASS_CHECKER_LOCKOUT_EN
        failNext  = failCount;
`endif
        case (state)
            IDLE, ENTRY: begin
                if (clearKey) begin
                    nextState = IDLE;
                end else if (enterKey) begin
                    if (digitCount == FULL) nextState = CHECK;
                    else if (digitCount != 4'd0) mismatch = 1'b1;
                end else if (digitValid && digitCount != FULL) begin
                    entryNext = {entryReg[27:0], digitIn};
                    countNext = digitCount + 4'd1;
                    nextState = ENTRY;
                end
            end
            CHECK: begin
                if (entryReg == keyPass) begin
                    nextState = OPEN;
`ifdef PASS_CHECKER_LOCKOUT_EN
                    failNext  = '0;
`endif
                end else begin
                    mismatch = 1'b1;
                end
            end
            OPEN: begin
                if (timer == CW'(OPEN_CYCLES - 1)) nextState = IDLE;
                else timerNext = timer + CW'(1);
            end
            FAIL: nextState = IDLE;
`ifdef PASS_CHECKER_LOCKOUT_EN
            LOCKOUT: begin
                if (timer == CW'(LOCKOUT_CYCLES - 1)) begin
                    nextState = IDLE;
                    failNext  = '0;
                end else begin
                    timerNext = timer + CW'(1);
                end
            end
`endif
            default: nextState = IDLE;
        endcase

        // Partial entries and CHECK mismatches share one failure path.
        if (mismatch) begin
`ifdef PASS_CHECKER_LOCKOUT_EN
            failNext  = failCount + CW'(1);
            nextState = (failNext == CW'(MAX_TRIES)) ? LOCKOUT : FAIL;
`else
            nextState = FAIL;
`endif
        end

        if (nextState != state) timerNext = '0;
        if (nextState == IDLE) begin
            entryNext = '0;
            countNext = '0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            entryReg   <= '0;
            digitCount <= '0;
            timer      <= '0;
`ifdef PASS_CHECKER_LOCKOUT_EN
            failCount  <= '0;
`endif
        end else begin
            // NOTE: sequential state uses non-blocking assignments only, so all registers update together.
            state      <= nextState;
            entryReg   <= entryNext;
            digitCount <= countNext;
            timer      <= timerNext;
`ifdef PASS_CHECKER_LOCKOUT_EN
            failCount  <= failNext;
`endif
        end
    end

    always_comb begin
        doorOpen  = (state == OPEN);
        failPulse = (state == FAIL);
        busy      = (state == CHECK) || (state == OPEN) || (state == FAIL);
`ifdef PASS_CHECKER_LOCKOUT_EN
        failPulse = failPulse || (state == LOCKOUT && timer == '0);
        locked    = (state == LOCKOUT);
        busy      = busy || (state == LOCKOUT);
`else
        locked    = 1'b0;
`endif
    end

endmodule

// File: tb/tb_pass_checker.sv
// Self-checking bench for pass_checker: directed scenarios plus randomized attempts
// judged against a per-attempt outcome model (cycle counts of each output).
module tb_pass_checker;
    localparam int OPEN_CYCLES    = 16;
    localparam int MAX_TRIES      = 3;
    localparam int LOCKOUT_CYCLES = 64;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] keyPass;
    logic        digitValid, enterKey, clearKey;
    logic [3:0]  digitIn;
    logic        doorOpen, failPulse, locked, busy;
    logic [3:0]  digitCount;

    int compared   = 0;
    int mismatched = 0;
    int modelFails = 0;
    int digs[16];
    int nDigs;

    pass_checker #(
        .OPEN_CYCLES(OPEN_CYCLES),
        .MAX_TRIES(MAX_TRIES),
        .LOCKOUT_CYCLES(LOCKOUT_CYCLES)
    ) dut (
        .clk(clk), .reset(reset), .keyPass(keyPass),
        .digitValid(digitValid), .digitIn(digitIn),
        .enterKey(enterKey), .clearKey(clearKey),
        .doorOpen(doorOpen), .failPulse(failPulse), .locked(locked),
        .digitCount(digitCount), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load_key_digits(input logic [31:0] key, input int n);
        nDigs = n;
        for (int i = 0; i < n; i++) digs[i] = (i < 8) ? int'((key >> (28 - 4 * i)) & 32'hF) : int'($urandom_range(0, 15));
    endtask

    task automatic press_digits(input string tag);
        int expCnt;
        for (int i = 0; i < nDigs; i++) begin
            digitValid = 1'b1;
            digitIn    = 4'(digs[i]);
            tick();
            digitValid = 1'b0;
            if ($urandom_range(0, 3) == 0) tick();
        end
        expCnt = (nDigs > 8) ? 8 : nDigs;
        compared++;
        if (digitCount !== 4'(expCnt)) begin
            mismatched++;
            $display("FAIL %s count: got %0d, expected %0d", tag, digitCount, expCnt);
        end
    endtask

    // Submits the buffered digits and measures how long each output stays high.
    task automatic attempt(input string tag, input logic [31:0] key);
        int cnt, checkCyc, expBusy, busyCyc, doorCyc, failCyc, lockCyc;
        logic [31:0] val;
        bit expOpen, expFail, expLock, done;
        keyPass = key;
        press_digits(tag);
        cnt = (nDigs > 8) ? 8 : nDigs;
        val = '0;
        for (int i = 0; i < cnt; i++) val = (val << 4) | 32'(digs[i] & 15);
        checkCyc = (cnt == 8) ? 1 : 0;
        expOpen = 0; expFail = 0; expLock = 0; expBusy = 0;
        if (cnt == 8 && val == key) begin
            expOpen = 1; modelFails = 0; expBusy = 1 + OPEN_CYCLES;
        end else if (cnt > 0) begin
            modelFails++;
            expFail = 1; expBusy = checkCyc + 1;
`ifdef PASS_CHECKER_LOCKOUT_EN
            if (modelFails == MAX_TRIES) begin
                expLock = 1; modelFails = 0; expBusy = checkCyc + LOCKOUT_CYCLES;
            end
`endif
        end

        enterKey = 1'b1;
        tick();
        enterKey = 1'b0;
        busyCyc = 0; doorCyc = 0; failCyc = 0; lockCyc = 0; done = 0;
        for (int i = 0; i < 400 && !done; i++) begin
            if (busy !== 1'b1) begin
                done = 1;
            end else begin
                busyCyc++;
                doorCyc += int'(doorOpen);
                failCyc += int'(failPulse);
                lockCyc += int'(locked);
                // Strobes while busy must be ignored.
                digitValid = 1'($urandom_range(0, 1));
                digitIn    = 4'($urandom_range(0, 15));
                enterKey   = 1'($urandom_range(0, 1));
                clearKey   = ($urandom_range(0, 3) == 0);
                tick();
            end
        end
        digitValid = 1'b0; enterKey = 1'b0; clearKey = 1'b0;

        compared++;
        if (!done) begin mismatched++; $display("FAIL %s timeout: busy still high after 400 cycles", tag); end
        compared++;
        if (busyCyc != expBusy) begin mismatched++; $display("FAIL %s busy: got %0d cycles, expected %0d", tag, busyCyc, expBusy); end
        compared++;
        if (doorCyc != expOpen * OPEN_CYCLES) begin mismatched++; $display("FAIL %s doorOpen: got %0d cycles, expected %0d", tag, doorCyc, expOpen * OPEN_CYCLES); end
        compared++;
        if (failCyc != int'(expFail)) begin mismatched++; $display("FAIL %s failPulse: got %0d cycles, expected %0d", tag, failCyc, expFail); end
        compared++;
        if (lockCyc != expLock * LOCKOUT_CYCLES) begin mismatched++; $display("FAIL %s locked: got %0d cycles, expected %0d", tag, lockCyc, expLock * LOCKOUT_CYCLES); end
        compared++;
        if (digitCount !== 4'd0) begin mismatched++; $display("FAIL %s count after: got %0d, expected 0", tag, digitCount); end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        compared++;
        if ({doorOpen, failPulse, locked, busy, digitCount} !== 8'h00) begin
            mismatched++;
            $display("FAIL reset outputs: got %b, expected 00000000", {doorOpen, failPulse, locked, busy, digitCount});
        end
        #2 reset = 1'b0;
        digitValid = 1'b1; digitIn = 4'h5;
        tick();
        digitValid = 1'b0;
        compared++;
        if (digitCount !== 4'd1) begin mismatched++; $display("FAIL first digit after reset: got %0d, expected 1", digitCount); end
        clearKey = 1'b1;
        tick();
        clearKey = 1'b0;
        compared++;
        if (digitCount !== 4'd0) begin mismatched++; $display("FAIL clear: got %0d, expected 0", digitCount); end
        modelFails = 0;
    endtask

    task automatic test_match();
        nDigs = 8;
        for (int i = 0; i < 8; i++) digs[i] = i + 1;
        attempt("match", 32'h12345678);
    endtask

    task automatic test_wrong();
        nDigs = 8;
        for (int i = 0; i < 7; i++) digs[i] = i + 1;
        digs[7] = 9;
        attempt("wrong", 32'h12345678);
    endtask

    task automatic test_overflow();
        nDigs = 9;
        for (int i = 0; i < 9; i++) digs[i] = i + 1;
        attempt("overflow", 32'h12345678);
    endtask

    task automatic test_partial();
        nDigs = 3;
        for (int i = 0; i < 3; i++) digs[i] = i + 1;
        attempt("partial", 32'h12345678);
        nDigs = 0;
        attempt("empty", 32'h12345678);
    endtask

    task automatic test_clear_priority();
        nDigs = 8;
        for (int i = 0; i < 8; i++) digs[i] = i + 1;
        keyPass = 32'h12345678;
        press_digits("clearpri");
        clearKey = 1'b1; enterKey = 1'b1; digitValid = 1'b1; digitIn = 4'h3;
        tick();
        clearKey = 1'b0; enterKey = 1'b0; digitValid = 1'b0;
        compared++;
        if ({busy, failPulse, digitCount} !== 6'd0) begin
            mismatched++;
            $display("FAIL clearpri: got busy/fail/count %b, expected 000000", {busy, failPulse, digitCount});
        end
        tick();
        compared++;
        if ({busy, failPulse} !== 2'b00) begin mismatched++; $display("FAIL clearpri next: got %b, expected 00", {busy, failPulse}); end
    endtask

    task automatic test_reset_mid_open();
        load_key_digits(32'h12345678, 8);
        keyPass = 32'h12345678;
        press_digits("midopen");
        enterKey = 1'b1;
        tick();
        enterKey = 1'b0;
        repeat (5) tick();
        compared++;
        if (doorOpen !== 1'b1) begin mismatched++; $display("FAIL midopen door: got %b, expected 1", doorOpen); end
        #2 reset = 1'b1;
        #1;
        compared++;
        if ({doorOpen, busy, digitCount} !== 6'd0) begin
            mismatched++;
            $display("FAIL midopen reset: got %b, expected 000000", {doorOpen, busy, digitCount});
        end
        tick();
        #2 reset = 1'b0;
        tick();
        compared++;
        if ({doorOpen, busy} !== 2'b00) begin mismatched++; $display("FAIL midopen release: got %b, expected 00", {doorOpen, busy}); end
        modelFails = 0;
        test_match();
    endtask

`ifdef PASS_CHECKER_LOCKOUT_EN
    task automatic test_lockout();
        logic [31:0] key;
        key = 32'hA5C3_0F19;
        for (int k = 0; k < MAX_TRIES; k++) begin
            load_key_digits(key ^ 32'h0000_0100, 8);
            attempt("lockout wrong", key);
        end
        load_key_digits(key, 8);
        attempt("lockout then match", key);
    endtask
`endif

    task automatic test_random();
        logic [31:0] key;
        for (int t = 0; t < 40; t++) begin
            key = $urandom;
            case ($urandom_range(0, 3))
                0: load_key_digits(key, 8);
                1: load_key_digits(key, 9);
                2: begin
                    nDigs = $urandom_range(0, 10);
                    for (int i = 0; i < nDigs; i++) digs[i] = $urandom_range(0, 15);
                end
                default: begin
                    load_key_digits(key, 8);
                    digs[$urandom_range(0, 7)] ^= $urandom_range(1, 15);
                end
            endcase
            attempt("random", key);
        end
    endtask

    task automatic test_back_to_back();
        for (int k = 0; k < 3; k++) begin
            load_key_digits(32'hDEADBEEF, 8);
            attempt("b2b", 32'hDEADBEEF);
        end
    endtask

    initial begin
        reset = 1'b1; keyPass = '0;
        digitValid = 1'b0; digitIn = '0; enterKey = 1'b0; clearKey = 1'b0;
        test_reset();
        test_match();
        test_wrong();
        test_overflow();
        test_partial();
        test_clear_priority();
        test_reset_mid_open();
`ifdef PASS_CHECKER_LOCKOUT_EN
        test_lockout();
`endif
        test_back_to_back();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
